// File: rtl/button_debouncer.sv
// Debounces a raw asynchronous push-button into a registered level plus
// single-cycle rise/fall pulses, using a 2-flop synchronizer and a counting FSM.
module button_debouncer #(
  parameter int STABLE_COUNT = 1_000_000,
  parameter int CNT_WIDTH    = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  typedef enum logic [1:0] {
    S_LOW   = 2'd0,
    S_WAITH = 2'd1,
    S_HIGH  = 2'd2,
    S_WAITL = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 sync1;
  logic                 sync2;
  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] counter;
  logic [CNT_WIDTH-1:0] counter_next;
  logic                 level_next;
  logic                 rise_next;
  logic                 fall_next;

  // Two-flop synchronizer; only sync2 is trusted downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // State register; the outputs are registered alongside the FSM so that
  // nothing downstream ever sees a combinational path from btn_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_LOW;
      counter   <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      btn_level <= level_next;
      btn_rise  <= rise_next;
      btn_fall  <= fall_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOW: begin
        if (sync2) state_next = S_WAITH;
      end
      S_WAITH: begin
        if (!sync2)                 state_next = S_LOW;
        else if (counter == CNT_LAST) state_next = S_HIGH;
      end
      S_HIGH: begin
        if (!sync2) state_next = S_WAITL;
      end
      S_WAITL: begin
        if (sync2)                  state_next = S_HIGH;
        else if (counter == CNT_LAST) state_next = S_LOW;
      end
      default: state_next = S_LOW;
    endcase
  end

  // Counter restarts on any disagreement, so a bounce discards all progress.
  always_comb begin
    counter_next = '0;
    level_next   = btn_level;
    rise_next    = 1'b0;
    fall_next    = 1'b0;
    case (state)
      S_LOW: begin
        if (sync2) counter_next = CNT_ONE;
      end
      S_WAITH: begin
        if (sync2) begin
          if (counter == CNT_LAST) begin
            level_next = 1'b1;
            rise_next  = 1'b1;
          end else begin
            counter_next = counter + CNT_ONE;
          end
        end
      end
      S_HIGH: begin
        if (!sync2) counter_next = CNT_ONE;
      end
      S_WAITL: begin
        if (!sync2) begin
          if (counter == CNT_LAST) begin
            level_next = 1'b0;
            fall_next  = 1'b1;
          end else begin
            counter_next = counter + CNT_ONE;
          end
        end
      end
      default: begin
        counter_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_COUNT=4: a vector table for
// press/glitch/release/bounce plus hand-written reset sequences.
module tb_button_debouncer;

  typedef struct {
    int   test_id;
    logic btn;
    logic exp_level;
    logic exp_rise;
    logic exp_fall;
  } vec_t;

  logic clk;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;

  int compared;
  int mismatched;
  vec_t vecs[$];

  button_debouncer #(
    .STABLE_COUNT(4),
    .CNT_WIDTH   (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input int id, input logic b, input logic l,
                         input logic r, input logic f);
    vec_t v;
    v.test_id   = id;
    v.btn       = b;
    v.exp_level = l;
    v.exp_rise  = r;
    v.exp_fall  = f;
    vecs.push_back(v);
  endtask

  task automatic check_output(input string name, input logic l,
                              input logic r, input logic f);
    compared++;
    if ({btn_level, btn_rise, btn_fall} !== {l, r, f}) begin
      mismatched++;
      $display("[TB] FAIL %s: got level/rise/fall=%b%b%b expected %b%b%b",
               name, btn_level, btn_rise, btn_fall, l, r, f);
    end
  endtask

  // Drive on the falling edge, then sample just after the following rising edge.
  task automatic apply_stimulus(input logic b);
    @(negedge clk);
    btn_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_idle();
    @(negedge clk);
    rst    = 1'b1;
    btn_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Test 2: clean press, captured at edge E, level/rise at E+5
    for (int i = 0; i < 5; i++) add_vec(2, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(2, 1'b1, 1'b1, 1'b1, 1'b0);
    add_vec(2, 1'b1, 1'b1, 1'b0, 1'b0);
    // Test 4: three-cycle low glitch while level=1
    for (int i = 0; i < 3; i++) add_vec(4, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) add_vec(4, 1'b1, 1'b1, 1'b0, 1'b0);
    // Test 5: clean release
    for (int i = 0; i < 5; i++) add_vec(5, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(5, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec(5, 1'b0, 1'b0, 1'b0, 1'b0);
    // Test 3: bounce 1,0,1,1,0 then steady 1
    add_vec(3, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(3, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(3, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(3, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(3, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) add_vec(3, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(3, 1'b1, 1'b1, 1'b1, 1'b0);
    add_vec(3, 1'b1, 1'b1, 1'b0, 1'b0);

    // Test 1: input held high through reset
    rst    = 1'b1;
    btn_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("t1_in_reset_%0d", i), 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("t1_after_release_edge%0d", i),
                   (i >= 6), (i == 6), 1'b0);
    end

    reset_idle();

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].btn);
      check_output($sformatf("t%0d_vec%0d", vecs[i].test_id, i),
                   vecs[i].exp_level, vecs[i].exp_rise, vecs[i].exp_fall);
    end

    // Asynchronous reset while level=1 clears the outputs without a clock edge
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_rst_from_high", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    btn_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Test 6: reset in S_WAITH, then a full restart is required
    @(negedge clk);
    btn_in = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("t6_async_rst_waith", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("t6_restart_edge%0d", i),
                   (i >= 6), (i == 6), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
